pll_lock_ctrl: RTL and testbench

Sequencing controller for the on-chip PLL. Pulses the PLL reset, waits for `lock`, qualifies it over a stability window, and releases a synchronous system reset to downstream logic. Runs on the free-running board clock that also feeds the PLL. Recovers automatically from lock loss and latches a fault after repeated lock timeouts.

---
 rtl/pll_lock_ctrl.sv | 157 +++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses pll_reset, qualifies lock, releases sys_rst.
// Optional lock-loss counter enabled by PLL_LOCK_CTRL_LOSS_CNT_EN.
module pll_lock_ctrl #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY        = 4,
  parameter int CNT_W            = 20
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       locked,
  output logic       fault,
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
  output logic [7:0] loss_cnt,
`endif
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FLT
  } state_t;

  localparam logic [CNT_W-1:0] RP_LAST =
    CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LAST =
    CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             lock_s;
  logic [2:0]       retry_nxt;

  assign retry_nxt = retry_cnt + 3'd1;

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= RST_PLL;
      cnt       <= '0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      locked    <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 3'd0;
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
      loss_cnt  <= 8'd0;
`endif
    end else begin
      case (state)
        RST_PLL: begin
          if (relock_req) begin
            cnt <= '0;
          end else if (cnt == RP_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (relock_req) begin
            state     <= RST_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
          end else if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            cnt       <= '0;
            pll_reset <= 1'b1;
            retry_cnt <= retry_nxt;
            if (retry_nxt == MAX_R) begin
              state <= FLT;
              fault <= 1'b1;
            end else begin
              state <= RST_PLL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          if (relock_req) begin
            state     <= RST_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
          end else if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == ST_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst   <= 1'b0;
            locked    <= 1'b1;
            retry_cnt <= 3'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s || relock_req) begin
            state     <= RST_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            locked    <= 1'b0;
          end
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
          // Only lock loss counts; a requested relock does not.
          if (!lock_s && loss_cnt != 8'hff)
            loss_cnt <= loss_cnt + 8'd1;
`endif
        end
        FLT: begin
          if (relock_req) begin
            state     <= RST_PLL;
            cnt       <= '0;
            fault     <= 1'b0;
            retry_cnt <= 3'd0;
          end
        end
        default: begin
          state     <= RST_PLL;
          cnt       <= '0;
          pll_reset <= 1'b1;
          sys_rst   <= 1'b1;
          locked    <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with short cycle parameters.
// Define PLL_LOCK_CTRL_LOSS_CNT_EN to also check loss_cnt.
module tb_pll_lock_ctrl;

  logic       clkin = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_rst;
  logic       locked;
  logic       fault;
  logic [2:0] retry_cnt;
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clkin = ~clkin;

  pll_lock_ctrl #(
    .RST_PULSE_CYC(4),
    .LOCK_STABLE_CYC(8),
    .LOCK_TIMEOUT_CYC(32),
    .MAX_RETRY(3),
    .CNT_W(20)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .pll_lock(pll_lock),
    .relock_req(relock_req),
    .pll_reset(pll_reset),
    .sys_rst(sys_rst),
    .locked(locked),
    .fault(fault),
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    .loss_cnt(loss_cnt),
`endif
    .retry_cnt(retry_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clkin);
      #1;
    end
  endtask

  // Called on a sample where pll_reset is high; counts that sample.
  task automatic pulse_len(output int len);
    len = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pll_reset) len++;
      else break;
    end
  endtask

  task automatic gap_len(output int len);
    len = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      len++;
      if (pll_reset) break;
    end
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pll_lock = 1'b0;
    relock_req = 1'b0;
    tick(3);
    check("rst_pll_reset", int'(pll_reset), 1);
    check("rst_sys_rst", int'(sys_rst), 1);
    check("rst_locked", int'(locked), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_retry", int'(retry_cnt), 0);
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    check("rst_loss", int'(loss_cnt), 0);
`endif

    // Clean lock
    reset = 1'b0;
    pulse_len(n);
    check("clean_pulse", n, 4);
    tick(10);
    pll_lock = 1'b1;
    tick(10);
    check("clean_locked_early", int'(locked), 0);
    check("clean_sys_rst_early", int'(sys_rst), 1);
    tick();
    check("clean_locked", int'(locked), 1);
    check("clean_sys_rst", int'(sys_rst), 0);
    check("clean_retry", int'(retry_cnt), 0);
    check("clean_pll_reset", int'(pll_reset), 0);

    // Lock loss in RUN
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    check("loss_locked_hold", int'(locked), 1);
    tick();
    check("loss_locked", int'(locked), 0);
    check("loss_sys_rst", int'(sys_rst), 1);
    check("loss_pll_reset", int'(pll_reset), 1);
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    check("loss_cnt1", int'(loss_cnt), 1);
`endif
    pulse_len(n);
    check("loss_pulse", n, 4);
    tick(8);
    check("loss_relock_early", int'(locked), 0);
    tick();
    check("loss_relock", int'(locked), 1);

    // Requested relock in RUN
    pulse_relock();
    check("req_pll_reset", int'(pll_reset), 1);
    check("req_locked", int'(locked), 0);
    check("req_sys_rst", int'(sys_rst), 1);
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    check("req_loss_cnt", int'(loss_cnt), 1);
`endif
    pulse_len(n);
    check("req_pulse", n, 4);
    tick(9);
    check("req_relock", int'(locked), 1);

    // Glitch during qualification
    pll_lock = 1'b0;
    tick(3);
    check("gl_pll_reset", int'(pll_reset), 1);
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    check("gl_loss_cnt2", int'(loss_cnt), 2);
`endif
    pulse_len(n);
    check("gl_pulse", n, 4);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick(10);
    check("gl_locked_early", int'(locked), 0);
    check("gl_retry", int'(retry_cnt), 0);
    tick();
    check("gl_locked", int'(locked), 1);

    // Timeouts into FAULT
    pll_lock = 1'b0;
    tick(3);
    pulse_len(n);
    check("to_pulse0", n, 4);
    for (int r = 1; r <= 3; r++) begin
      gap_len(n);
      check($sformatf("to_gap%0d", r), n, 32);
      check($sformatf("to_retry%0d", r), int'(retry_cnt), r);
      if (r < 3) begin
        pulse_len(n);
        check($sformatf("to_pulse%0d", r), n, 4);
      end
    end
    check("flt_fault", int'(fault), 1);
    tick(5);
    check("flt_hold_fault", int'(fault), 1);
    check("flt_hold_pll_reset", int'(pll_reset), 1);
    check("flt_hold_retry", int'(retry_cnt), 3);
    check("flt_sys_rst", int'(sys_rst), 1);
    pulse_relock();
    check("flt_clr_fault", int'(fault), 0);
    check("flt_clr_retry", int'(retry_cnt), 0);
    pulse_len(n);
    check("flt_pulse", n, 4);

    // Reset asserted in STABLE
    pll_lock = 1'b1;
    tick(4);
    check("st_locked", int'(locked), 0);
    reset = 1'b1;
    tick();
    check("st_rst_pll_reset", int'(pll_reset), 1);
    check("st_rst_sys_rst", int'(sys_rst), 1);
    check("st_rst_locked", int'(locked), 0);
    check("st_rst_fault", int'(fault), 0);
    check("st_rst_retry", int'(retry_cnt), 0);
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    check("st_rst_loss", int'(loss_cnt), 0);
`endif
    tick();
    reset = 1'b0;
    pulse_len(n);
    check("st_pulse", n, 4);
    tick(8);
    check("st_locked_early", int'(locked), 0);
    tick();
    check("st_locked_final", int'(locked), 1);
    check("st_sys_rst_final", int'(sys_rst), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
